// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Pulled in by mem_arbiter_if, mem_arb_grant and mem_arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REQ    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester identities: the data port and the instruction-fetch port
  typedef logic req_id_t;
  localparam req_id_t REQ_DATA  = 1'b0;
  localparam req_id_t REQ_FETCH = 1'b1;

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    return (id == REQ_FETCH) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester handshakes and the single-port memory bus.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0_valid;
  logic              req1_valid;
  logic              req0_we;
  logic              req1_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [DATA_W-1:0] req1_wdata;
  logic              req0_ready;
  logic              req1_ready;
  logic              req0_rvalid;
  logic              req1_rvalid;
  logic [DATA_W-1:0] rdata;

  logic              W;
  logic [ADDR_W-1:0] realaddr;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] din;

  modport slave (
    input  req0_valid, req1_valid, req0_we, req1_we,
           req0_addr, req1_addr, req0_wdata, req1_wdata, din,
    output req0_ready, req1_ready, req0_rvalid, req1_rvalid, rdata,
           W, realaddr, dout
  );

  modport master (
    output req0_valid, req1_valid, req0_we, req1_we,
           req0_addr, req1_addr, req0_wdata, req1_wdata, din,
    input  req0_ready, req1_ready, req0_rvalid, req1_rvalid, rdata,
           W, realaddr, dout
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Combinational grant selection: request valids (+ priority pointer) -> one-hot grant.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise requester 0 always wins.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
`ifdef MEM_ARB_RR_EN
  input  req_id_t            prio,
`endif
  output logic [NUM_REQ-1:0] grant
);

`ifdef MEM_ARB_RR_EN
  // prio names the requester that wins a tie; a lone valid always wins
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = id_onehot(prio);
    end
  end
`else
  always_comb begin
    grant    = '0;
    grant[0] = valid[0];
    grant[1] = valid[1] & ~valid[0];
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory: IDLE -> ACCESS -> RESP.
// Define MEM_ARB_RR_EN for round-robin tie-break; default build is fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  state_t              state;
  state_t              next_state;
  logic [NUM_REQ-1:0]  valid;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  ready;
  logic                handshake;
  req_id_t             hs_id;

  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic                we_q;
  req_id_t             gid_q;

  assign valid = {bus.req1_valid, bus.req0_valid};

`ifdef MEM_ARB_RR_EN
  req_id_t prio_q;

  // After each handshake the other requester gets the next tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= REQ_DATA;
    end else if (handshake) begin
      prio_q <= ~hs_id;
    end
  end

  mem_arb_grant u_grant (
    .valid (valid),
    .prio  (prio_q),
    .grant (grant)
  );
`else
  mem_arb_grant u_grant (
    .valid (valid),
    .grant (grant)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    ready      = '0;
    case (state)
      IDLE: begin
        ready = grant;
        if (|grant) begin
          next_state = ACCESS;
        end
      end
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign handshake = |ready;
  assign hs_id     = ready[REQ_FETCH];

  assign sel_we    = hs_id ? bus.req1_we    : bus.req0_we;
  assign sel_addr  = hs_id ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = hs_id ? bus.req1_wdata : bus.req0_wdata;

  // Memory-side outputs come straight from flops so the memory never sees a glitch.
  // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      rvalid_q  <= '0;
      we_q      <= 1'b0;
      gid_q     <= REQ_DATA;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            we_q      <= sel_we;
            gid_q     <= hs_id;
          end
        end
        ACCESS: begin
          mem_we   <= 1'b0;
          rvalid_q <= id_onehot(gid_q);
          if (!we_q) begin
            rdata_q <= bus.din;
          end
        end
        RESP: begin
          rvalid_q <= '0;
        end
        default: begin
          mem_we   <= 1'b0;
          rvalid_q <= '0;
        end
      endcase
    end
  end

  assign bus.req0_ready  = ready[0];
  assign bus.req1_ready  = ready[1];
  assign bus.req0_rvalid = rvalid_q[0];
  assign bus.req1_rvalid = rvalid_q[1];
  assign bus.rdata       = rdata_q;
  assign bus.W           = mem_we;
  assign bus.realaddr    = mem_addr;
  assign bus.dout        = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and a response scoreboard.
// Expectations follow MEM_ARB_RR_EN when the bench is built with it defined.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural single-port memory: combinational read, write on W at the clock edge
  logic [DW-1:0] mem [0:65535];
  logic          pre_en   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  assign bus.din = mem[bus.realaddr];

  always @(posedge clk) begin
    if (bus.W) mem[bus.realaddr] <= bus.dout;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] rdata_model = '0;
  int            prio_model  = 0;
  int            errors      = 0;
  int            checks      = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  function automatic int exp_winner(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef MEM_ARB_RR_EN
      return prio_model;
`else
      return 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
    ref_mem[int'(a)] = d;
  endtask

  task automatic drive(input int id, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic set_valid(input int id, input logic v);
    if (id == 0) bus.req0_valid = v;
    else         bus.req1_valid = v;
  endtask

  // Wait (bounded) for a grant; report who got it and after how many cycles
  task automatic wait_grant(input string tag, output int gid, output int cycles);
    gid    = -1;
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        cycles = i;
        break;
      end
    end
    check({tag, " ready seen"}, 32'(bus.req0_ready | bus.req1_ready), 32'd1);
    if (cycles != 0) begin
      check({tag, " single ready"}, 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      check({tag, " no rvalid in idle"}, 32'({bus.req1_rvalid, bus.req0_rvalid}), 32'd0);
      gid = bus.req1_ready ? 1 : 0;
    end
  endtask

  // Called at the IDLE negedge where the grant is visible; returns at the RESP negedge
  task automatic complete(input string tag, input int id, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input bit drop);
    exp_t e;
    exp_t got;
    if (!we) rdata_model = ref_rd(a);
    e.id   = id;
    e.data = rdata_model;
    sb.push_back(e);
    if (we) ref_mem[int'(a)] = d;
    prio_model = 1 - id;

    @(posedge clk);
    #1 if (drop) set_valid(id, 1'b0);

    @(negedge clk);
    check({tag, " access W"}, 32'(bus.W), 32'(we));
    check({tag, " access realaddr"}, 32'(bus.realaddr), 32'(a));
    if (we) check({tag, " access dout"}, bus.dout, d);
    check({tag, " no ready in access"}, 32'({bus.req1_ready, bus.req0_ready}), 32'd0);

    @(negedge clk);
    check({tag, " resp W low"}, 32'(bus.W), 32'd0);
    check({tag, " no ready in resp"}, 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    check({tag, " rvalid seen"}, 32'(bus.req0_rvalid | bus.req1_rvalid), 32'd1);
    if (bus.req0_rvalid || bus.req1_rvalid) begin
      got = sb.pop_front();
      check({tag, " rvalid0"}, 32'(bus.req0_rvalid), 32'(got.id == 0));
      check({tag, " rvalid1"}, 32'(bus.req1_rvalid), 32'(got.id == 1));
      check({tag, " rdata"}, bus.rdata, got.data);
    end
  endtask

  initial begin
    int g;
    int c;
    int other;

    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    preload(16'h0001, 32'h1111_0001);
    preload(16'h0002, 32'h2222_0002);
    preload(16'h0003, 32'h3333_0003);
    preload(16'h0004, 32'h4444_0004);
    preload(16'hFFFF, 32'h1234_5678);
    preload(16'h0020, 32'h0BAD_0BAD);

    @(negedge clk);
    check("reset W", 32'(bus.W), 32'd0);
    check("reset realaddr", 32'(bus.realaddr), 32'd0);
    check("reset dout", bus.dout, 32'd0);
    check("reset rdata", bus.rdata, 32'd0);
    check("reset rvalid", 32'({bus.req1_rvalid, bus.req0_rvalid}), 32'd0);
    check("reset no ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Write then read back through the data port
    drive(0, 1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
    wait_grant("wr0", g, c);
    check("wr0 winner", 32'(g), 32'd0);
    check("wr0 first grant latency", 32'(c), 32'd1);
    complete("wr0", 0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 1'b1);

    drive(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    wait_grant("rd0", g, c);
    check("rd0 winner", 32'(g), 32'd0);
    check("rd0 three-cycle spacing", 32'(c), 32'd1);
    complete("rd0", 0, 1'b0, 16'h0010, 32'h0, 1'b1);

    // Both requesters valid at once
    drive(0, 1'b1, 1'b0, 16'h0001, 32'h0);
    drive(1, 1'b1, 1'b0, 16'h0002, 32'h0);
    wait_grant("tie", g, c);
    check("tie first winner", 32'(g), 32'(exp_winner(1'b1, 1'b1)));
    complete("tie first", g, 1'b0, (g == 0) ? 16'h0001 : 16'h0002, 32'h0, 1'b1);
    other = 1 - g;
    wait_grant("tie second", g, c);
    check("tie second winner", 32'(g), 32'(other));
    check("tie second spacing", 32'(c), 32'd1);
    complete("tie second", g, 1'b0, (g == 0) ? 16'h0001 : 16'h0002, 32'h0, 1'b1);

    // Both held valid across four transactions
    drive(0, 1'b1, 1'b0, 16'h0003, 32'h0);
    drive(1, 1'b1, 1'b0, 16'h0004, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("held%0d", k), g, c);
      check($sformatf("held%0d winner", k), 32'(g), 32'(exp_winner(1'b1, 1'b1)));
      check($sformatf("held%0d spacing", k), 32'(c), 32'd1);
      complete($sformatf("held%0d", k), g, 1'b0, (g == 0) ? 16'h0003 : 16'h0004, 32'h0, 1'b0);
    end
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);

    // Reset in the middle of a write access
    drive(0, 1'b1, 1'b1, 16'h0020, 32'hCAFE_F00D);
    wait_grant("abort", g, c);
    @(posedge clk);
    #1 set_valid(0, 1'b0);
    @(negedge clk);
    check("abort W before reset", 32'(bus.W), 32'd1);
    check("abort realaddr before reset", 32'(bus.realaddr), 32'h0020);
    #1 reset = 1'b1;
    #1;
    check("abort W drops", 32'(bus.W), 32'd0);
    check("abort realaddr cleared", 32'(bus.realaddr), 32'd0);
    check("abort dout cleared", bus.dout, 32'd0);
    check("abort rdata cleared", bus.rdata, 32'd0);
    check("abort rvalid cleared", 32'({bus.req1_rvalid, bus.req0_rvalid}), 32'd0);
    rdata_model = '0;
    prio_model  = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Top-of-memory read on the fetch port, right after reset
    drive(1, 1'b1, 1'b0, 16'hFFFF, 32'h0);
    wait_grant("rd1 top", g, c);
    check("rd1 top winner", 32'(g), 32'd1);
    check("first grant after reset", 32'(c), 32'd1);
    complete("rd1 top", 1, 1'b0, 16'hFFFF, 32'h0, 1'b1);

    // Aborted write must not have reached memory
    drive(0, 1'b1, 1'b0, 16'h0020, 32'h0);
    wait_grant("rd0 aborted addr", g, c);
    complete("rd0 aborted addr", 0, 1'b0, 16'h0020, 32'h0, 1'b1);

    // A valid raised only during RESP and withdrawn gets no service
    drive(1, 1'b1, 1'b0, 16'h0002, 32'h0);
    wait_grant("rd1 short", g, c);
    complete("rd1 short", 1, 1'b0, 16'h0002, 32'h0, 1'b1);
    drive(0, 1'b1, 1'b1, 16'h0030, 32'h55AA_55AA);
    #1 check("short valid no ready in resp", 32'(bus.req0_ready), 32'd0);
    @(posedge clk);
    #1 set_valid(0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("short valid idle%0d ready", k), 32'(bus.req0_ready), 32'd0);
      check($sformatf("short valid idle%0d W", k), 32'(bus.W), 32'd0);
      check($sformatf("short valid idle%0d rvalid", k), 32'({bus.req1_rvalid, bus.req0_rvalid}), 32'd0);
    end

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
